// File: rtl/hack_rom_loader.sv
// Purpose : boot loader for the Hack CPU. Parses SYNC-framed big-endian 16-bit words from a byte
//           stream, writes them to instruction ROM from address 0, and releases the CPU reset only
//           once the frame checksum has verified.
// Latency : the ROM write strobe is high for one cycle, starting on the edge after the word's low
//           byte is accepted. Status changes on the edge that accepts the deciding byte.
// Backpr. : rx_ready is always 1 once out of reset, so one byte can be consumed every cycle.
//
// Ports:
//   i_clk        system clock (rising edge)
//   i_rst_n      asynchronous active-low reset
//   i_rx_data    byte from the serial receiver
//   i_rx_valid   i_rx_data is valid this cycle
//   o_rx_ready   loader accepts a byte this cycle (low only while reset is held)
//   o_rom_we     one-cycle ROM write strobe
//   o_rom_addr   ROM write address
//   o_rom_wdata  ROM write data
//   o_cpu_reset  active-high CPU reset; low only while a verified image is present
//   o_busy       a frame is in progress
//   o_done       last frame verified, CPU running
//   o_error      last frame rejected
module hack_rom_loader #(
   parameter int          ADDR_W = 15,
   parameter logic [7:0]  SYNC   = 8'hA5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rx_ready,
   output logic              o_rom_we,
   output logic [ADDR_W-1:0] o_rom_addr,
   output logic [15:0]       o_rom_wdata,
   output logic              o_cpu_reset,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error
);

   // Largest image that fits in the ROM, in words.
   localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CNT_HI,
      S_CNT_LO,
      S_DAT_HI,
      S_DAT_LO,
      S_CK_HI,
      S_CK_LO,
      S_RUN,
      S_ERR
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic                r_rdy;
   logic [7:0]          r_hi;      // latched high byte (count, data or checksum)
   logic [15:0]         r_cnt;     // N for the current frame
   logic [15:0]         r_wcnt;    // words written so far in this frame
   logic [15:0]         r_acc;     // running checksum
   logic                r_we;
   logic [15:0]         r_wdata;
   logic [ADDR_W-1:0]   r_addr;

   logic                w_accept;
   logic [15:0]         w_word;
   logic                w_oversize;
   logic                w_last;
   logic                w_ck_ok;
   logic                w_latch_hi;
   logic                w_clr;
   logic                w_wr;

   // rx_ready is a flop so it stays low for the whole reset and rises one edge after release.
   assign w_accept   = i_rx_valid & r_rdy;
   assign w_word     = {r_hi, i_rx_data};
   assign w_oversize = {16'd0, w_word} > MAX_WORDS;
   assign w_last     = (r_wcnt == (r_cnt - 16'd1));
   assign w_ck_ok    = (w_word == r_acc);

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------------------------------------------------------
   // Next state, datapath controls and state-decoded outputs
   // ---------------------------------------------------------------
   always_comb begin
      w_next      = r_state;
      w_latch_hi  = 1'b0;
      w_clr       = 1'b0;
      w_wr        = 1'b0;
      o_cpu_reset = 1'b1;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_error     = 1'b0;

      case (r_state)
         S_RUN: begin
            o_cpu_reset = 1'b0;
            o_done      = 1'b1;
         end
         S_ERR:  o_error = 1'b1;
         S_IDLE: ;
         default: o_busy = 1'b1;
      endcase

      if (w_accept) begin
         case (r_state)
            // Outside a frame only SYNC matters; everything else is dropped.
            S_IDLE, S_RUN, S_ERR: begin
               if (i_rx_data == SYNC) begin
                  w_next = S_CNT_HI;
               end
            end
            S_CNT_HI: begin
               w_latch_hi = 1'b1;
               w_next     = S_CNT_LO;
            end
            S_CNT_LO: begin
               // Accumulator is cleared even for an empty frame so an old sum cannot leak in.
               w_clr = 1'b1;
               if (w_oversize) begin
                  w_next = S_ERR;
               end else if (w_word == 16'd0) begin
                  w_next = S_CK_HI;
               end else begin
                  w_next = S_DAT_HI;
               end
            end
            S_DAT_HI: begin
               w_latch_hi = 1'b1;
               w_next     = S_DAT_LO;
            end
            S_DAT_LO: begin
               w_wr   = 1'b1;
               w_next = w_last ? S_CK_HI : S_DAT_HI;
            end
            S_CK_HI: begin
               w_latch_hi = 1'b1;
               w_next     = S_CK_LO;
            end
            S_CK_LO: begin
               w_next = w_ck_ok ? S_RUN : S_ERR;
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdy   <= 1'b0;
         r_hi    <= 8'd0;
         r_cnt   <= 16'd0;
         r_wcnt  <= 16'd0;
         r_acc   <= 16'd0;
         r_we    <= 1'b0;
         r_wdata <= 16'd0;
         r_addr  <= '0;
      end else begin
         r_rdy <= 1'b1;
         r_we  <= w_wr;

         if (w_latch_hi) begin
            r_hi <= i_rx_data;
         end

         if (w_wr) begin
            r_wdata <= w_word;
         end

         if (w_clr) begin
            r_cnt  <= w_word;
            r_wcnt <= 16'd0;
            r_acc  <= 16'd0;
         end else if (w_wr) begin
            r_wcnt <= r_wcnt + 16'd1;
            r_acc  <= r_acc + w_word;
         end

         // The address moves on only after the write cycle, so it is stable while r_we is high.
         // A clear and a write strobe can never coincide: CNT_LO is at least two bytes after DAT_LO.
         if (w_clr) begin
            r_addr <= '0;
         end else if (r_we) begin
            r_addr <= r_addr + ADDR_W'(1);
         end
      end
   end

   assign o_rx_ready  = r_rdy;
   assign o_rom_we    = r_we;
   assign o_rom_addr  = r_addr;
   assign o_rom_wdata = r_wdata;

endmodule

// File: tb/tb_hack_rom_loader.sv
module tb_hack_rom_loader;

   localparam int AW = 15;

   logic          clk;
   logic          rst_n;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          rom_we;
   logic [AW-1:0] rom_addr;
   logic [15:0]   rom_wdata;
   logic          cpu_reset;
   logic          busy;
   logic          done;
   logic          error;

   hack_rom_loader #(.ADDR_W(AW), .SYNC(8'hA5)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_rx_data   (rx_data),
      .i_rx_valid  (rx_valid),
      .o_rx_ready  (rx_ready),
      .o_rom_we    (rom_we),
      .o_rom_addr  (rom_addr),
      .o_rom_wdata (rom_wdata),
      .o_cpu_reset (cpu_reset),
      .o_busy      (busy),
      .o_done      (done),
      .o_error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- write monitor ----------------
   typedef struct packed {
      logic [AW-1:0] a;
      logic [15:0]   d;
   } wr_t;

   wr_t         wq[$];
   logic [15:0] exp_q[$];
   logic        prev_we = 1'b0;

   always @(negedge clk) begin
      if (rom_we) begin
         wq.push_back(wr_t'{a: rom_addr, d: rom_wdata});
         check("we_inside_frame", busy, 1);
         check("we_single_cycle", prev_we, 0);
      end
      prev_we = rom_we;
   end

   // Writes of a complete frame always land at 0,1,2,... with the frame's words in order.
   task automatic check_writes(input string name);
      check({name, "_nwrites"}, wq.size(), exp_q.size());
      for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s_addr%0d", name, i), 32'(wq[i].a), i);
         check($sformatf("%s_data%0d", name, i), 32'(wq[i].d), 32'(exp_q[i]));
      end
      wq.delete();
      exp_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_r(input logic [7:0] b);
      send_byte(b);
      if ($urandom_range(0, 3) == 0) idle(1);
   endtask

   task automatic check_status(input string name, input logic e_done, input logic e_err,
                               input logic e_busy);
      check({name, "_done"},      done,      e_done);
      check({name, "_error"},     error,     e_err);
      check({name, "_busy"},      busy,      e_busy);
      check({name, "_cpu_reset"}, cpu_reset, !e_done);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [95:0] bytes;   // left-aligned byte string
      int          len;
      logic [31:0] wd;      // expected write data, last word in the low half
      int          nw;
      logic        done_e;
      logic        err_e;
      logic        busy_e;
   } vec_t;

   vec_t vt[11];

   initial begin
      logic [15:0] sum;
      logic [15:0] w;
      logic [15:0] n;
      logic [7:0]  g;
      logic        good;
      int          mode;
      int          nwords;

      vt[0]  = '{96'h00FF_A500_0212_34AB_CDBE_0100, 11, 32'h1234_ABCD, 2, 1'b1, 1'b0, 1'b0};
      vt[1]  = '{96'hA500_0100_0700_0800_0000_0000,  7, 32'h0000_0007, 1, 1'b0, 1'b1, 1'b0};
      vt[2]  = '{96'hA500_0100_0700_0700_0000_0000,  7, 32'h0000_0007, 1, 1'b1, 1'b0, 1'b0};
      vt[3]  = '{96'hA580_0100_0000_0000_0000_0000,  3, 32'h0,         0, 1'b0, 1'b1, 1'b0};
      vt[4]  = '{96'hA500_0000_0000_0000_0000_0000,  5, 32'h0,         0, 1'b1, 1'b0, 1'b0};
      vt[5]  = '{96'h1122_3300_0000_0000_0000_0000,  3, 32'h0,         0, 1'b1, 1'b0, 1'b0};
      vt[6]  = '{96'hA500_01A5_A5A5_A500_0000_0000,  7, 32'h0000_A5A5, 1, 1'b1, 1'b0, 1'b0};
      vt[7]  = '{96'hA500_0200_0000_0000_0000_0000,  3, 32'h0,         0, 1'b0, 1'b0, 1'b1};
      vt[8]  = '{96'h0001_0002_0003_0000_0000_0000,  6, 32'h0001_0002, 2, 1'b1, 1'b0, 1'b0};
      vt[9]  = '{96'hA500_0000_0100_0000_0000_0000,  5, 32'h0,         0, 1'b0, 1'b1, 1'b0};
      vt[10] = '{96'hA500_01FF_FFFF_FF00_0000_0000,  7, 32'h0000_FFFF, 1, 1'b1, 1'b0, 1'b0};

      // ---------------- reset ----------------
      rst_n    = 1'b0;
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      idle(3);
      check("rst_rx_ready",  rx_ready,  0);
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_rom_we",    rom_we,    0);
      check("rst_rom_addr",  32'(rom_addr),  0);
      check("rst_rom_wdata", 32'(rom_wdata), 0);
      check("rst_busy",      busy,      0);
      check("rst_done",      done,      0);
      check("rst_error",     error,     0);
      rst_n = 1'b1;
      idle(1);
      // rx_ready was still low on that edge, so the held SYNC must not have been taken.
      check("rel_rx_ready", rx_ready, 1);
      check("rel_busy",     busy,     0);
      rx_valid = 1'b0;
      idle(1);

      // ---------------- table vectors ----------------
      for (int k = 0; k < 11; k++) begin
         for (int i = 0; i < vt[k].len; i++) begin
            send_byte(vt[k].bytes[95 - 8*i -: 8]);
         end
         check_status($sformatf("vec%0d", k), vt[k].done_e, vt[k].err_e, vt[k].busy_e);
         idle(2);
         if (vt[k].nw == 2) exp_q.push_back(vt[k].wd[31:16]);
         if (vt[k].nw >= 1) exp_q.push_back(vt[k].wd[15:0]);
         check_writes($sformatf("vec%0d", k));
      end

      // ---------------- write timing, then reset mid-frame ----------------
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
      send_byte(8'h11); send_byte(8'h11);
      check("wt_we_hi",   rom_we, 1);
      check("wt_addr0",   32'(rom_addr), 0);
      check("wt_wdata",   32'(rom_wdata), 32'h1111);
      check("wt_busy",    busy, 1);
      idle(1);
      check("wt_we_lo",   rom_we, 0);
      check("wt_addr1",   32'(rom_addr), 1);
      send_byte(8'h22); send_byte(8'h22);
      check("wt2_we_hi",  rom_we, 1);
      check("wt2_addr",   32'(rom_addr), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_rom_we",    rom_we, 0);
      check("mrst_rom_addr",  32'(rom_addr), 0);
      check("mrst_rom_wdata", 32'(rom_wdata), 0);
      check("mrst_cpu_reset", cpu_reset, 1);
      check("mrst_busy",      busy, 0);
      check("mrst_rx_ready",  rx_ready, 0);
      exp_q.push_back(16'h1111);
      check_writes("mrst");
      idle(1);
      rst_n = 1'b1;
      idle(2);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h20);
      send_byte(8'h00); send_byte(8'h30);
      check_status("reload", 1, 0, 0);
      idle(2);
      exp_q.push_back(16'h0010);
      exp_q.push_back(16'h0020);
      check_writes("reload");

      // ---------------- SYNC while running ----------------
      send_byte(8'hA5);
      check("runsync_cpu_reset", cpu_reset, 1);
      check("runsync_done",      done, 0);
      check("runsync_busy",      busy, 1);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check_status("runsync_end", 1, 0, 0);
      idle(2);
      check_writes("runsync");

      // ---------------- randomized frames vs frame-level model ----------------
      for (int f = 0; f < 25; f++) begin
         for (int p = $urandom_range(0, 3); p > 0; p--) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            send_r(g);
         end
         mode = $urandom_range(0, 9);
         if (mode == 0) begin
            n = 16'($urandom_range(32769, 65535));
            send_r(8'hA5); send_r(n[15:8]); send_r(n[7:0]);
            check_status($sformatf("rnd%0d", f), 0, 1, 0);
         end else begin
            nwords = $urandom_range(0, 6);
            n      = 16'(nwords);
            sum    = 16'd0;
            send_r(8'hA5); send_r(n[15:8]); send_r(n[7:0]);
            for (int i = 0; i < nwords; i++) begin
               w = 16'($urandom);
               exp_q.push_back(w);
               sum = sum + w;
               send_r(w[15:8]); send_r(w[7:0]);
            end
            good = (mode > 2);
            if (!good) sum = sum + 16'($urandom_range(1, 65535));
            send_r(sum[15:8]); send_r(sum[7:0]);
            check_status($sformatf("rnd%0d", f), good, !good, 0);
         end
         idle(2);
         check_writes($sformatf("rnd%0d", f));
      end

      // ---------------- maximum image: 2^15 words ----------------
      sum = 16'd0;
      send_byte(8'hA5); send_byte(8'h80); send_byte(8'h00);
      for (int i = 0; i < 32768; i++) begin
         w = 16'($urandom);
         exp_q.push_back(w);
         sum = sum + w;
         send_byte(w[15:8]); send_byte(w[7:0]);
      end
      send_byte(sum[15:8]); send_byte(sum[7:0]);
      check_status("big", 1, 0, 0);
      idle(2);
      if (wq.size() == 0) begin
         check("big_any_write", 0, 1);
      end else begin
         check("big_last_addr", 32'(wq[wq.size()-1].a), 32'h7FFF);
      end
      check_writes("big");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hack_rom_loader.md
# hack_rom_loader

Boot loader that sits directly upstream of the Hack CPU's instruction port. It receives a framed byte stream from a serial receiver and assembles big-endian 16-bit instruction words. It writes them sequentially into instruction ROM from address 0 and holds the CPU in reset until the whole image has loaded and its checksum has verified. It owns the CPU's reset line, so the CPU's `reset` input is driven from `cpu_reset`.

## Interface
- `ADDR_W`, default 15: ROM address width; maximum image length is 2^ADDR_W words.
- `SYNC`, default 8'hA5: frame start byte.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  byte from the serial receiver.
- `rx_valid`  in  1  `rx_data` is valid this cycle.
- `rx_ready`  out  1  loader accepts a byte this cycle. A byte is consumed when `rx_valid & rx_ready`.
- `rom_we`  out  1  one-cycle ROM write strobe.
- `rom_addr`  out  ADDR_W  ROM write address.
- `rom_wdata`  out  16  ROM write data.
- `cpu_reset`  out  1  active-high reset to the CPU; high whenever no verified image is present.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  last frame verified; CPU running.
- `error`  out  1  last frame rejected.

## Operation
- Frame format, in byte order:
  - `SYNC`
  - count high byte, count low byte (N words)
  - N words, each high byte then low byte
  - checksum high byte, checksum low byte
- Checksum = sum of the N data words mod 2^16.
- States: IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, CK_HI, CK_LO, RUN, ERR.
- `rx_ready` is 1 in every state after reset is released. It is 0 only while `reset` is asserted.
- State transitions, each on a consumed byte:
  - IDLE, ERR, RUN: a `SYNC` byte goes to CNT_HI. Any other byte is discarded and the state is unchanged.
  - CNT_HI to CNT_LO.
  - CNT_LO:
    - N > 2^ADDR_W: go to ERR.
    - N = 0: go to CK_HI.
    - Otherwise: go to DAT_HI, with word counter and address cleared to 0 and checksum accumulator cleared.
  - DAT_HI latches the high byte and goes to DAT_LO.
  - DAT_LO forms the word. On the next edge: `rom_we`=1, `rom_wdata`=word, `rom_addr`=current address, and the accumulator adds the word.
    - After the last word: go to CK_HI.
    - Otherwise: go to DAT_HI.
  - CK_HI to CK_LO.
  - CK_LO:
    - Checksum equals accumulator: go to RUN.
    - Otherwise: go to ERR.
- `rom_addr` increments by 1 after each write pulse. Because N ≤ 2^ADDR_W, it never wraps within a frame.
- Output levels by state:
  - `cpu_reset` = 0 only in RUN.
  - `busy` = 1 in CNT_HI through CK_LO.
  - `done` = 1 only in RUN.
  - `error` = 1 only in ERR.
- A `SYNC` byte received in RUN starts a reload and reasserts `cpu_reset` from the next cycle.
- Inside a frame (CNT_HI through CK_LO) every byte is payload. A `SYNC` value there has no special meaning.

## Timing
- Reset values: state IDLE, `rx_ready`=0 while held, `rom_we`=0, `rom_addr`=0, `rom_wdata`=0, `cpu_reset`=1, `busy`=0, `done`=0, `error`=0. Accumulator, counter and byte latch are all 0.
- Reset asserted mid-frame:
  - All outputs return to reset values immediately (asynchronously).
  - Any pending write is dropped.
  - No partial state survives.
- One byte can be consumed per cycle, so back-to-back `rx_valid` is supported.
- Write latency: `rom_we` is high exactly one cycle, on the edge after the DAT_LO byte is accepted. `rom_addr`/`rom_wdata` are stable during that cycle.
- `cpu_reset` falls, and `done` rises, on the edge that accepts a matching CK_LO byte. That edge is at least one cycle after the final `rom_we` pulse.
- `error` rises on the edge accepting the rejecting byte: CNT_LO for an oversize count, CK_LO for a bad checksum. `error` clears on the edge accepting the next `SYNC`.
- `rom_we` never pulses in ERR, RUN or IDLE.

## Test plan
- Reset: hold `reset`=0 with `rx_valid`=1 -> `cpu_reset`=1, `rom_we`=0, `rom_addr`=0, `rx_ready`=0, `busy`/`done`/`error`=0. Release -> `rx_ready`=1 next cycle.
- Good load: bytes 00 FF A5 00 02 12 34 AB CD BE 01, sent back-to-back ->
  - 00 FF ignored.
  - Writes 0x1234@0, then 0xABCD@1, one `rom_we` cycle each.
  - Final byte -> `cpu_reset`=0, `done`=1, `busy`=0.
- Bad checksum: A5 00 01 00 07 00 08 ->
  - One write, 0x0007@0.
  - `error`=1, `cpu_reset` stays 1.
  - Then A5 00 01 00 07 00 07 -> `error`=0, `done`=1, `cpu_reset`=0.
- Oversize/empty:
  - A5 80 01 -> `error`=1 after the third byte, no `rom_we`.
  - A5 80 00, then 32768 words, then correct checksum -> last write at `rom_addr`=0x7FFF, `done`=1.
  - A5 00 00 00 00 -> `done`=1 with zero writes.
- Mid-operation events:
  - Assert `reset` after the first word of a 4-word frame -> outputs reset immediately. A new full frame then loads from address 0.
  - In RUN, send A5 -> `cpu_reset`=1 and `done`=0 on the next cycle, `busy`=1.
